pa_elastic_pipe: RTL and testbench
==================================

// Module: pa_elastic_pipe
// PURPOSE
//  Parametrised successor to the fixed per-stage inter-stage registers.
//  Carries a WIDTH-bit payload through DEPTH register stages with a
//  valid/ready handshake on each stage, so a downstream stall back-pressures
//  cleanly. Adds a synchronous flush (branch kill), an optional input skid
//  buffer that breaks the combinational ready path, and an occupancy count.
//  Sits between any two stages: fetch/decode, decode/execute, execute/writeback.
// PARAMETERS
//  WIDTH  32  payload width in bits (>=1)
//  DEPTH  1   number of register stages (>=1)
//  SKID   0   0: in_ready is combinational from out_ready; 1: 1-entry input skid buffer, in_ready registered
//  CNT_W  $clog2(DEPTH+2)  width of occupancy (localparam; holds DEPTH+SKID)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous reset, active low
//  flush      in   1      synchronous kill of all in-flight entries
//  in_valid   in   1      upstream has payload
//  in_ready   out  1      block accepts payload this cycle
//  in_data    in   WIDTH  payload
//  out_valid  out  1      last stage holds payload
//  out_ready  in   1      downstream accepts payload
//  out_data   out  WIDTH  payload of last stage
//  occupancy  out  CNT_W  valid entries held (stages + skid)
// BEHAVIOUR
//  Reset (rst_n=0 at a rising edge): all stage valids=0, skid valid=0, occupancy=0.
//   out_valid=0; out_data is don't-care but must not be X after the first accept.
//   in_ready=0 while rst_n=0.
//  Transfer rules:
//   - in: accepted on an edge where in_valid&in_ready.
//   - out: popped on an edge where out_valid&out_ready.
//  Stage i (0..DEPTH-1, DEPTH-1 = output) advances when ready_i = ~v_i | ready_{i+1},
//   with ready_DEPTH = out_ready. All stages move in the same edge (no bubbles).
//   Full throughput is 1 item/cycle.
//  Latency: when the pipe is empty and not stalled, an item accepted at edge E
//   gives out_valid=1 after edge E+DEPTH-1, i.e. DEPTH cycles in to out.
//   The skid does not add latency when not stalled.
//  SKID=0: in_ready = ready_0 & ~flush & rst_n (combinational).
//  SKID=1: in_ready = ~skid_v (registered).
//   - Accept while ready_0=0: payload goes to the skid.
//   - While skid_v: stage 0 loads from the skid, not in_data.
//   - skid_v clears on the edge the skid drains into stage 0.
//  Data must hold in any stage whose valid=1 and ready_{i+1}=0 (no overwrite, no drop).
//  Ordering: strict FIFO; no duplication.
//  Flush (edge with flush=1):
//   - all valids and skid_v -> 0, occupancy -> 0.
//   - in_ready=0 in the flush cycle, so nothing is accepted.
//   - a pop in the same cycle still counts as delivered downstream.
//   - flush during back-pressure discards held data.
//  Priority: rst_n=0 > flush > normal operation.
//  occupancy_next = occupancy + accept - pop, saturating impossible by construction.
//   Max value is DEPTH+SKID. Simultaneous accept and pop leaves it unchanged.
//  out_data and out_valid come straight from stage DEPTH-1 registers (no comb path from in_*).
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with in_valid=1, in_data=32'hDEAD
//    -> out_valid=0, occupancy=0, in_ready=0; first cycle after release in_ready=1.
//  2 Stream DEPTH=3: in_data=1..10 back-to-back, out_ready=1
//    -> out_data 1..10 on consecutive cycles, first 3 cycles after first accept; occupancy steady at 3.
//  3 Back-pressure DEPTH=3 SKID=0: fill 1..3, out_ready=0 for 5 cycles
//    -> in_ready=0, out_data holds 1, occupancy=3; release -> 1,2,3 in order, none lost.
//  4 SKID=1 DEPTH=2: out_ready drops in the same cycle in_valid=1 with data 7
//    -> 7 captured in skid, in_ready=0 next cycle, occupancy=3; after release order is preserved.
//  5 Flush: 3 items in flight plus in_valid=1 with data 9, flush=1 for one cycle
//    -> next cycle out_valid=0, occupancy=0, 9 never appears at output.
//  6 DEPTH=1, WIDTH=5: random valid/ready 1000 cycles vs reference queue model
//    -> no mismatch, no loss/dup, occupancy matches model every cycle.

Source files
------------

// File: rtl/pa_elastic_pipe_if.sv
// Valid/ready stream bundle for pa_elastic_pipe.
// slave = the pipe, master = whatever drives and drains it.
interface pa_elastic_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pa_elastic_pipe.sv
// Elastic DEPTH-stage valid/ready pipe with flush,
// optional input skid entry and occupancy count.
module pa_elastic_pipe #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 1,
  parameter  int SKID  = 0,
  localparam int CNT_W = $clog2(DEPTH + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  pa_elastic_pipe_if.slave   io,
  output logic [CNT_W-1:0]   occupancy
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic             src_v;
  logic [WIDTH-1:0] src_d;
  logic             acc;
  logic             pop;

  assign acc = io.in_valid & io.in_ready;
  assign pop = io.out_valid & io.out_ready;

  assign io.out_valid = v[DEPTH-1];
  assign io.out_data  = d[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    logic             pv;
    logic [WIDTH-1:0] pd;
    logic             sv;
    logic [WIDTH-1:0] sd;

    // a stage can move if any stage from here to the output
    // has a hole, or the consumer takes the last one
    assign rdy[i] = io.out_ready | ~(&v[DEPTH-1:i]);

    if (i == 0) begin : g_head
      assign pv = src_v;
      assign pd = src_d;
    end else begin : g_body
      assign pv = v[i-1];
      assign pd = d[i-1];
    end

    // stage register: load from predecessor when free to advance
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sv <= 1'b0;
        sd <= '0;
      end else if (flush) begin
        sv <= 1'b0;
      end else if (rdy[i]) begin
        sv <= pv;
        if (pv) sd <= pd;
      end
    end

    assign v[i] = sv;
    assign d[i] = sd;
  end

  if (SKID != 0) begin : g_skid
    logic             skid_v;
    logic [WIDTH-1:0] skid_d;

    assign io.in_ready = ~skid_v & ~flush & rst_n;
    assign src_v       = skid_v | acc;
    assign src_d       = skid_v ? skid_d : io.in_data;

    // park an accept that stage 0 cannot take; drain when it frees
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        skid_v <= 1'b0;
        skid_d <= '0;
      end else if (flush) begin
        skid_v <= 1'b0;
      end else if (acc && !rdy[0]) begin
        skid_v <= 1'b1;
        skid_d <= io.in_data;
      end else if (skid_v && rdy[0]) begin
        skid_v <= 1'b0;
      end
    end
  end else begin : g_noskid
    assign io.in_ready = rdy[0] & ~flush & rst_n;
    assign src_v       = acc;
    assign src_d       = io.in_data;
  end

  // held-entry count: +1 per accept, -1 per pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + CNT_W'(acc) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_pa_elastic_pipe.sv
// Bench for pa_elastic_pipe: directed scenarios on three
// configurations plus randomized runs against a queue model.
module tb_pa_elastic_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic flush = 1'b0;

  logic [2:0] occ_a;
  logic [1:0] occ_b;
  logic [1:0] occ_c;

  int errs = 0;
  int checks = 0;

  pa_elastic_pipe_if #(.WIDTH(32)) ia ();
  pa_elastic_pipe_if #(.WIDTH(32)) ib ();
  pa_elastic_pipe_if #(.WIDTH(5))  ic ();

  pa_elastic_pipe #(.WIDTH(32), .DEPTH(3), .SKID(0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .io(ia), .occupancy(occ_a)
  );

  pa_elastic_pipe #(.WIDTH(32), .DEPTH(2), .SKID(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .io(ib), .occupancy(occ_b)
  );

  pa_elastic_pipe #(.WIDTH(5), .DEPTH(1), .SKID(0)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .io(ic), .occupancy(occ_c)
  );

  task automatic idle_all();
    ia.in_valid = 1'b0; ia.in_data = '0; ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.in_data = '0; ib.out_ready = 1'b0;
    ic.in_valid = 1'b0; ic.in_data = '0; ic.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush = 1'b0;
    idle_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    ia.in_valid = 1'b1;
    ia.in_data = 32'hDEAD;
    ia.out_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ia.out_valid !== 1'b0) begin
        errs++; $display("FAIL rst_out_valid: got %b exp 0", ia.out_valid);
      end
      checks++;
      if (occ_a !== 3'd0) begin
        errs++; $display("FAIL rst_occ: got %0d exp 0", occ_a);
      end
      checks++;
      if (ia.in_ready !== 1'b0) begin
        errs++; $display("FAIL rst_in_ready: got %b exp 0", ia.in_ready);
      end
      checks++;
      if (ib.in_ready !== 1'b0) begin
        errs++; $display("FAIL rst_in_ready_skid: got %b exp 0", ib.in_ready);
      end
    end
    rst_n = 1'b1;
    ia.in_valid = 1'b0;
    #1;
    checks++;
    if (ia.in_ready !== 1'b1) begin
      errs++; $display("FAIL rst_release_ready: got %b exp 1", ia.in_ready);
    end
    checks++;
    if (ib.in_ready !== 1'b1) begin
      errs++; $display("FAIL rst_release_ready_skid: got %b exp 1", ib.in_ready);
    end
  endtask

  task automatic test_stream();
    int eo;
    int popped;
    logic ev;
    do_reset();
    ia.out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      ia.in_valid = (c < 10);
      ia.in_data = 32'(c + 1);
      #1;
      ev = (c >= 3) && (c <= 12);
      popped = (c - 3 < 0) ? 0 : ((c - 3 > 10) ? 10 : c - 3);
      eo = ((c < 10) ? c : 10) - popped;
      checks++;
      if (ia.out_valid !== ev) begin
        errs++; $display("FAIL stream_valid c=%0d: got %b exp %b", c, ia.out_valid, ev);
      end
      if (ev) begin
        checks++;
        if (ia.out_data !== 32'(c - 2)) begin
          errs++; $display("FAIL stream_data c=%0d: got %0d exp %0d", c, ia.out_data, c - 2);
        end
      end
      checks++;
      if (occ_a !== 3'(eo)) begin
        errs++; $display("FAIL stream_occ c=%0d: got %0d exp %0d", c, occ_a, eo);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ia.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ia.in_valid = 1'b1;
      ia.in_data = 32'(c + 1);
      #1;
      checks++;
      if (ia.in_ready !== 1'b1) begin
        errs++; $display("FAIL bp_fill_ready c=%0d: got %b exp 1", c, ia.in_ready);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 5; c++) begin
      ia.in_valid = 1'b1;
      ia.in_data = 32'd99;
      #1;
      checks++;
      if (ia.in_ready !== 1'b0) begin
        errs++; $display("FAIL bp_stall_ready c=%0d: got %b exp 0", c, ia.in_ready);
      end
      checks++;
      if (ia.out_valid !== 1'b1 || ia.out_data !== 32'd1) begin
        errs++; $display("FAIL bp_hold c=%0d: got v=%b d=%0d exp v=1 d=1", c, ia.out_valid, ia.out_data);
      end
      checks++;
      if (occ_a !== 3'd3) begin
        errs++; $display("FAIL bp_occ c=%0d: got %0d exp 3", c, occ_a);
      end
      @(negedge clk);
    end
    ia.in_valid = 1'b0;
    ia.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (c < 3) begin
        if (ia.out_valid !== 1'b1 || ia.out_data !== 32'(c + 1)) begin
          errs++; $display("FAIL bp_drain c=%0d: got v=%b d=%0d exp d=%0d", c, ia.out_valid, ia.out_data, c + 1);
        end
      end else begin
        if (ia.out_valid !== 1'b0 || occ_a !== 3'd0) begin
          errs++; $display("FAIL bp_empty: got v=%b occ=%0d exp v=0 occ=0", ia.out_valid, occ_a);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_skid();
    do_reset();
    ib.out_ready = 1'b1;
    ib.in_valid = 1'b1;
    ib.in_data = 32'd11;
    @(negedge clk);
    ib.in_valid = 1'b0;
    #1;
    checks++;
    if (ib.out_valid !== 1'b0) begin
      errs++; $display("FAIL skid_lat_early: got %b exp 0", ib.out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ib.out_valid !== 1'b1 || ib.out_data !== 32'd11) begin
      errs++; $display("FAIL skid_lat: got v=%b d=%0d exp v=1 d=11", ib.out_valid, ib.out_data);
    end
    @(negedge clk);
    ib.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ib.in_valid = 1'b1;
      ib.in_data = 32'(c + 5);
      #1;
      checks++;
      if (ib.in_ready !== 1'b1) begin
        errs++; $display("FAIL skid_fill_ready c=%0d: got %b exp 1", c, ib.in_ready);
      end
      @(negedge clk);
    end
    ib.in_valid = 1'b1;
    ib.in_data = 32'd8;
    #1;
    checks++;
    if (ib.in_ready !== 1'b0) begin
      errs++; $display("FAIL skid_full_ready: got %b exp 0", ib.in_ready);
    end
    checks++;
    if (occ_b !== 2'd3) begin
      errs++; $display("FAIL skid_occ: got %0d exp 3", occ_b);
    end
    checks++;
    if (ib.out_data !== 32'd5) begin
      errs++; $display("FAIL skid_hold: got %0d exp 5", ib.out_data);
    end
    @(negedge clk);
    ib.in_valid = 1'b0;
    ib.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (c < 3) begin
        if (ib.out_valid !== 1'b1 || ib.out_data !== 32'(c + 5)) begin
          errs++; $display("FAIL skid_drain c=%0d: got v=%b d=%0d exp d=%0d", c, ib.out_valid, ib.out_data, c + 5);
        end
      end else begin
        if (ib.out_valid !== 1'b0 || occ_b !== 2'd0) begin
          errs++; $display("FAIL skid_empty: got v=%b occ=%0d exp v=0 occ=0", ib.out_valid, occ_b);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    do_reset();
    ia.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ia.in_valid = 1'b1;
      ia.in_data = 32'(c + 1);
      @(negedge clk);
    end
    ia.in_data = 32'd9;
    flush = 1'b1;
    #1;
    checks++;
    if (ia.in_ready !== 1'b0) begin
      errs++; $display("FAIL flush_ready: got %b exp 0", ia.in_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    ia.in_valid = 1'b0;
    ia.out_ready = 1'b1;
    #1;
    checks++;
    if (ia.out_valid !== 1'b0 || occ_a !== 3'd0) begin
      errs++; $display("FAIL flush_clear: got v=%b occ=%0d exp v=0 occ=0", ia.out_valid, occ_a);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ia.out_valid !== 1'b0) begin
        errs++; $display("FAIL flush_leak c=%0d: got v=%b d=%0d exp v=0", c, ia.out_valid, ia.out_data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random_depth1();
    logic [4:0] q[$];
    logic exp_ready;
    logic mpop;
    logic macc;
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      ic.in_valid = ($urandom_range(0, 3) != 0);
      ic.out_ready = ($urandom_range(0, 2) != 0);
      ic.in_data = 5'($urandom);
      flush = ($urandom_range(0, 49) == 0);
      #1;
      exp_ready = !flush && (q.size() == 0 || ic.out_ready);
      checks++;
      if (ic.in_ready !== exp_ready) begin
        errs++; $display("FAIL rnd1_ready c=%0d: got %b exp %b", c, ic.in_ready, exp_ready);
      end
      checks++;
      if (ic.out_valid !== (q.size() != 0)) begin
        errs++; $display("FAIL rnd1_valid c=%0d: got %b exp %b", c, ic.out_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if (ic.out_data !== q[0]) begin
          errs++; $display("FAIL rnd1_data c=%0d: got %0d exp %0d", c, ic.out_data, q[0]);
        end
      end
      checks++;
      if (occ_c !== 2'(q.size())) begin
        errs++; $display("FAIL rnd1_occ c=%0d: got %0d exp %0d", c, occ_c, q.size());
      end
      mpop = (q.size() != 0) && ic.out_ready;
      macc = ic.in_valid && exp_ready;
      if (mpop) void'(q.pop_front());
      if (flush) q.delete();
      else if (macc) q.push_back(ic.in_data);
      @(negedge clk);
    end
    flush = 1'b0;
  endtask

  task automatic test_random_skid();
    logic [31:0] q[$];
    logic macc;
    logic mpop;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      ib.in_valid = ($urandom_range(0, 3) != 0);
      ib.out_ready = ($urandom_range(0, 1) != 0);
      ib.in_data = $urandom;
      flush = ($urandom_range(0, 63) == 0);
      #1;
      checks++;
      if (occ_b !== 2'(q.size())) begin
        errs++; $display("FAIL rndk_occ c=%0d: got %0d exp %0d", c, occ_b, q.size());
      end
      if (ib.out_valid) begin
        checks++;
        if (q.size() == 0 || ib.out_data !== q[0]) begin
          errs++; $display("FAIL rndk_data c=%0d: got %0h exp %0h n=%0d", c, ib.out_data, (q.size() != 0) ? q[0] : 32'd0, q.size());
        end
      end
      if (q.size() == 3 || flush) begin
        checks++;
        if (ib.in_ready !== 1'b0) begin
          errs++; $display("FAIL rndk_full_ready c=%0d: got %b exp 0", c, ib.in_ready);
        end
      end
      macc = ib.in_valid && ib.in_ready;
      mpop = ib.out_valid && ib.out_ready;
      if (mpop && q.size() != 0) void'(q.pop_front());
      if (flush) q.delete();
      else if (macc) q.push_back(ib.in_data);
      @(negedge clk);
    end
    flush = 1'b0;
  endtask

  initial begin
    idle_all();
    test_reset();
    test_stream();
    test_backpressure();
    test_skid();
    test_flush();
    test_random_depth1();
    test_random_skid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
